rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameters SHALL be:
  ADDR_W  8  ROM address width
  DATA_W  8  ROM data width
  ROM_LAT  1  ROM read latency in cycles (>=1)
REQ-002 Ports SHALL be:
  clk  input  1  single clock, all logic on rising edge
  rst_n  input  1  synchronous active-low reset
  req  input  2  per-requester read request, level
  addr_0  input  ADDR_W  requester 0 address, stable while req[0]=1
  addr_1  input  ADDR_W  requester 1 address, stable while req[1]=1
  gnt  output  2  one-hot grant pulse, one cycle
  rvalid  output  2  one-hot read-data-valid pulse, one cycle
  rdata  output  DATA_W  read data, valid when rvalid!=0
  busy  output  1  high in any state other than IDLE
  rom_en  output  1  ROM enable
  rom_addr  output  ADDR_W  ROM address
  rom_dout  input  DATA_W  ROM read data

Function
REQ-003 FSM SHALL have states IDLE, READ, RESP; one ROM access in flight at most.
REQ-004 IDLE: with req!=0 at the rising edge, SHALL pick a winner, latch its address, and enter READ; with req=0, stay in IDLE.
REQ-005 First READ cycle: gnt[winner] SHALL be 1 for exactly that cycle.
REQ-006 READ SHALL last ROM_LAT+1 cycles, tracked by a latency counter; rom_en=1 and rom_addr=latched address throughout READ, stable.
REQ-007 The edge leaving READ SHALL capture rom_dout into rdata; RESP SHALL last 1 cycle with rvalid[winner]=1; then IDLE.
REQ-008 rom_en SHALL be 0 and rom_addr SHALL hold 0 outside READ.
REQ-009 Latency: req first sampled in IDLE at cycle N -> rvalid at cycle N+ROM_LAT+2; throughput one access per ROM_LAT+3 cycles.
REQ-010 rdata SHALL hold its last captured value until the next capture.
REQ-011 Request arriving while busy=1 SHALL wait; it is evaluated on the first IDLE cycle after RESP.
REQ-012 Requester still holding req after its rvalid SHALL be treated as a new request.
REQ-013 Address 0 and all-ones (0xFF for ADDR_W=8) SHALL pass unmodified; no address arithmetic.

Reset
REQ-014 rst_n=0 at a rising edge SHALL force IDLE, gnt=0, rvalid=0, rdata=0, busy=0, rom_en=0, rom_addr=0, counter=0, last-winner=1.
REQ-015 Reset during READ or RESP SHALL drop the access; no rvalid SHALL follow.

Configuration
REQ-016 With ROM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester not granted last (round-robin); last-winner SHALL update on every grant.
REQ-017 Without ROM_ARB_RR_EN: requester 0 SHALL always win simultaneous requests (fixed priority); last-winner register SHALL be absent.
REQ-018 A lone requester SHALL be granted in both configurations.

Structure
REQ-019 Package rom_arb_pkg SHALL hold the state_t enum (IDLE, READ, RESP), NUM_REQ=2, default ADDR_W/DATA_W.
REQ-020 Sub-module rom_arb_pick SHALL contain the combinational winner selection (req, last-winner -> one-hot pick), with the configuration macro handled inside it.

Verification (bench ROM model: mem[a]=a^8'hA5, ROM_LAT=1)
REQ-021 rst_n=0 for 2 cycles with req=2'b11 -> all outputs 0, busy=0, no gnt.
REQ-022 req[0]=1, addr_0=8'h01 at cycle N -> gnt=2'b01 at N+1; rom_en=1, rom_addr=8'h01 for N+1..N+2; rvalid=2'b01, rdata=8'hA4 at N+3.
REQ-023 req=2'b11 held for 4 transactions -> gnt order 01,10,01,10 with ROM_ARB_RR_EN; 01,01,01,01 without.
REQ-024 req[1]=1, addr_1=8'hFF asserted during requester 0 READ -> served after RESP; rvalid=2'b10, rdata=8'h5A.
REQ-025 rst_n=0 in the second READ cycle -> next cycle IDLE, rom_en=0; rvalid stays 0.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection for the ROM arbiter.
// ROM_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
`ifdef ROM_ARB_RR_EN
    input  logic               last_i,
`endif
    output logic [NUM_REQ-1:0] pick_o
);

    always_comb begin
        pick_o = '0;
        if (req_i[0] && req_i[1]) begin
`ifdef ROM_ARB_RR_EN
            // last_i is the index of the previous winner; hand the grant to the other one.
            pick_o = last_i ? 2'b01 : 2'b10;
`else
            pick_o = 2'b01;
`endif
        end else begin
            pick_o = req_i;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter sharing one fixed-latency ROM; one access in flight at a time.
// Define ROM_ARB_RR_EN for round-robin contention handling (default: fixed priority).
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0]  addr_0,
    input  logic [ADDR_W-1:0]  addr_1,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rvalid,
    output logic [DATA_W-1:0]  rdata,
    output logic               busy,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_dout
);

    localparam int unsigned CntW = $clog2(ROM_LAT + 2);

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_REQ-1:0]   win_q, win_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   pick;
`ifdef ROM_ARB_RR_EN
    logic                 last_q, last_d;
`endif

    rom_arb_pick u_pick (
        .req_i  (req),
`ifdef ROM_ARB_RR_EN
        .last_i (last_q),
`endif
        .pick_o (pick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        win_d   = win_q;
        rdata_d = rdata_q;
`ifdef ROM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = READ;
                    cnt_d   = '0;
                    win_d   = pick;
                    addr_d  = pick[0] ? addr_0 : addr_1;
`ifdef ROM_ARB_RR_EN
                    last_d  = pick[1];
`endif
                end
            end
            READ: begin
                // ROM_LAT+1 cycles in READ: data is on rom_dout by the last one.
                if (cnt_q == CntW'(ROM_LAT)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    rdata_d = rom_dout;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            win_q   <= '0;
            rdata_q <= '0;
`ifdef ROM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            win_q   <= win_d;
            rdata_q <= rdata_d;
`ifdef ROM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign rom_en   = (state_q == READ);
    assign rom_addr = rom_en ? addr_q : '0;
    assign gnt      = (state_q == READ && cnt_q == '0) ? win_q : '0;
    assign rvalid   = (state_q == RESP) ? win_q : '0;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a one-cycle-latency ROM model (mem[a] = a ^ 8'hA5).
module tb_rom_arbiter;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] addr_0, addr_1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       busy, rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_dout = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rom_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .ROM_LAT (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr_0   (addr_0),
        .addr_1   (addr_1),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_addr ^ 8'hA5;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        req   = 2'b00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_addr();
        case ($urandom_range(3, 0))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(255, 0));
        endcase
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 2'b11;
        addr_0 = 8'h33;
        addr_1 = 8'h44;
        step();
        step();
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 00", rvalid); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h exp 00", rdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b exp 0", rom_en); end
        n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h exp 00", rom_addr); end
        req   = 2'b00;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req    = 2'b01;
        addr_0 = 8'h01;
        step();  // N+1: first READ cycle
        req = 2'b00;
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b exp 01", gnt); end
        n_checks++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL single_en1: got %b exp 1", rom_en); end
        n_checks++; if (rom_addr !== 8'h01) begin n_fail++; $display("FAIL single_addr1: got %h exp 01", rom_addr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
        step();  // N+2
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_pulse: got %b exp 00", gnt); end
        n_checks++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL single_en2: got %b exp 1", rom_en); end
        n_checks++; if (rom_addr !== 8'h01) begin n_fail++; $display("FAIL single_addr2: got %h exp 01", rom_addr); end
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_rv_early: got %b exp 00", rvalid); end
        step();  // N+3: RESP
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL single_rvalid: got %b exp 01", rvalid); end
        n_checks++; if (rdata !== 8'hA4) begin n_fail++; $display("FAIL single_rdata: got %h exp a4", rdata); end
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL single_en_resp: got %b exp 0", rom_en); end
        n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL single_addr_resp: got %h exp 00", rom_addr); end
        step();  // N+4: IDLE
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_rv_pulse: got %b exp 00", rvalid); end
        n_checks++; if (rdata !== 8'hA4) begin n_fail++; $display("FAIL single_rdata_hold: got %h exp a4", rdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_order [4];
        logic [1:0] e_w;
        logic [7:0] e_d;
        int         prev;
        int         n;
`ifdef ROM_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        apply_reset();
        req    = 2'b11;
        addr_0 = 8'h10;
        addr_1 = 8'h20;
        prev   = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt === 2'b00 && n < 12) begin
                step();
                n++;
            end
            if (n >= 12) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_timeout: got no gnt exp gnt within 12 cycles (txn %0d)", k);
                break;
            end
            e_w = exp_order[k];
            e_d = (e_w[0] ? 8'h10 : 8'h20) ^ 8'hA5;
            n_checks++; if (gnt !== e_w) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b exp %b", k, gnt, e_w); end
            if (k > 0) begin
                n_checks++;
                if (cyc - prev !== LAT + 3) begin
                    n_fail++; $display("FAIL b2b_period%0d: got %0d exp %0d", k, cyc - prev, LAT + 3);
                end
            end
            prev = cyc;
            step();
            step();
            n_checks++; if (rvalid !== e_w) begin n_fail++; $display("FAIL b2b_rv%0d: got %b exp %b", k, rvalid, e_w); end
            n_checks++; if (rdata !== e_d) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h exp %h", k, rdata, e_d); end
            if (k == 3) req = 2'b00;
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_wait_busy();
        req    = 2'b01;
        addr_0 = 8'h05;
        step();  // READ, requester 0
        req    = 2'b10;
        addr_1 = 8'hFF;
        step();
        step();  // RESP for requester 0
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL wait_rv0: got %b exp 01", rvalid); end
        n_checks++; if (rdata !== 8'hA0) begin n_fail++; $display("FAIL wait_rdata0: got %h exp a0", rdata); end
        step();  // IDLE, request 1 evaluated here
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wait_no_gnt: got %b exp 00", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: got %b exp 0", busy); end
        step();
        req = 2'b00;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL wait_gnt1: got %b exp 10", gnt); end
        n_checks++; if (rom_addr !== 8'hFF) begin n_fail++; $display("FAIL wait_addr1: got %h exp ff", rom_addr); end
        step();
        step();
        n_checks++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL wait_rv1: got %b exp 10", rvalid); end
        n_checks++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL wait_rdata1: got %h exp 5a", rdata); end
        step();
    endtask

    task automatic test_reset_mid_read();
        req    = 2'b10;
        addr_1 = 8'h00;
        step();
        req = 2'b00;
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rmr_gnt: got %b exp 10", gnt); end
        step();  // second READ cycle
        n_checks++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL rmr_en: got %b exp 1", rom_en); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy: got %b exp 0", busy); end
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rmr_en_off: got %b exp 0", rom_en); end
        n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL rmr_addr: got %h exp 00", rom_addr); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rmr_rdata: got %h exp 00", rdata); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rmr_rv%0d: got %b exp 00", i, rvalid); end
            step();
        end
    endtask

    task automatic test_random();
        bit         active;
        int         start;
        logic [1:0] mwin, e_gnt, e_rv;
        logic [7:0] maddr, mrdata, e_addr;
        logic       e_en, e_busy;
`ifdef ROM_ARB_RR_EN
        bit         mlast;
        mlast = 1'b1;
`endif
        apply_reset();
        active = 1'b0;
        start  = 0;
        mwin   = 2'b00;
        maddr  = 8'h00;
        mrdata = 8'h00;
        for (int c = 0; c < 400; c++) begin
            // Expected outputs follow from the start cycle of the access in flight.
            e_gnt  = (active && c == start + 1) ? mwin : 2'b00;
            e_en   = active && c >= start + 1 && c <= start + 1 + LAT;
            e_rv   = (active && c == start + LAT + 2) ? mwin : 2'b00;
            e_busy = active && c >= start + 1 && c <= start + LAT + 2;
            e_addr = e_en ? maddr : 8'h00;
            if (e_rv != 2'b00) mrdata = maddr ^ 8'hA5;
            n_checks++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b exp %b", c, gnt, e_gnt); end
            n_checks++; if (rom_en !== e_en) begin n_fail++; $display("FAIL rnd_en c%0d: got %b exp %b", c, rom_en, e_en); end
            n_checks++; if (rom_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, rom_addr, e_addr); end
            n_checks++; if (rvalid !== e_rv) begin n_fail++; $display("FAIL rnd_rv c%0d: got %b exp %b", c, rvalid, e_rv); end
            n_checks++; if (rdata !== mrdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h exp %h", c, rdata, mrdata); end
            n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b exp %b", c, busy, e_busy); end
            for (int i = 0; i < 2; i++) begin
                if (req[i]) begin
                    if (e_rv[i] && $urandom_range(1, 0) == 1) req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    if (i == 0) addr_0 = rnd_addr();
                    else        addr_1 = rnd_addr();
                end
            end
            if ((!active || c >= start + LAT + 3) && req != 2'b00) begin
                if (req == 2'b11) begin
`ifdef ROM_ARB_RR_EN
                    mwin = mlast ? 2'b01 : 2'b10;
`else
                    mwin = 2'b01;
`endif
                end else begin
                    mwin = req;
                end
`ifdef ROM_ARB_RR_EN
                mlast = mwin[1];
`endif
                maddr  = mwin[0] ? addr_0 : addr_1;
                start  = c;
                active = 1'b1;
            end
            step();
        end
        req = 2'b00;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 2'b00;
        addr_0 = 8'h00;
        addr_1 = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_wait_busy();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
